mac_seq_ctrl: RTL and testbench
===============================

// Module: mac_seq_ctrl
// PURPOSE
//  Job sequencer for the 16-lane MAC array (mac_16 and its per-lane MAC_datapath units).
//  - Accepts one GEMM tile command: mode, K-depth and buffer base addresses.
//  - Clears the array, then steps K passes of 16 slots each. On every slot it issues
//    A/B buffer read addresses and drives the one-hot mode lines.
//  - Holds a result-ready handshake until the downstream drain has consumed the latch array.
// PARAMETERS
//  ADDR_W  10  width of the A/B operand-buffer addresses
//  K_W     8   width of the K-depth (pass count) field
//  SLOTS   16  slots per pass; must equal the array's latch-slot count
// PORTS
//  clk          in   1       single clock for the whole block
//  rst_n        in   1       asynchronous, active-low reset
//  cmd_valid    in   1       command offered
//  cmd_ready    out  1       command accepted when cmd_valid && cmd_ready
//  cmd_mode     in   2       0=INT8, 1=INT4, 2=VSQ, 3=illegal
//  cmd_k        in   K_W     number of passes
//  cmd_a_base   in   ADDR_W  A-buffer base address
//  cmd_b_base   in   ADDR_W  B-buffer base address
//  buf_rd_en    out  1       A/B buffer read strobe
//  a_addr       out  ADDR_W  A-buffer read address
//  b_addr       out  ADDR_W  B-buffer read address
//  mac_rst_n    out  1       active-low clear for the MAC array (accumulators and slot counter)
//  is_int8_mode out  1       mode line to the array
//  is_int4_mode out  1       mode line to the array
//  is_vsq       out  1       mode line to the array
//  res_valid    out  1       latch array holds the final tile result
//  res_ready    in   1       drain engine has consumed the result
//  done         out  1       one-cycle pulse when a job ends
//  err          out  1       sticky illegal-mode flag; cleared on the next accepted command
// BEHAVIOUR
//  Reset values: all outputs 0, except cmd_ready=1 and mac_rst_n=1. FSM returns to IDLE.
//  FSM states: IDLE -> CLEAR -> RUN -> DRAIN -> IDLE.
//  IDLE
//   - cmd_ready=1. On accept, latch mode, k and both bases; clear err.
//   - mode==3: set err, pulse done next cycle, stay IDLE.
//  CLEAR
//   - Exactly 1 cycle with mac_rst_n=0 and cmd_ready=0.
//   - This aligns the array's internal slot counter with this block's slot counter (both 0).
//   - k==0: next state is DRAIN, RUN is skipped; result is all zeros.
//  RUN
//   - Lasts exactly 16*k cycles. slot counts 0..SLOTS-1 and wraps; pass increments on wrap.
//   - Per cycle: buf_rd_en=1, a_addr=a_base+pass*SLOTS+slot, b_addr=b_base+pass.
//     Both addresses wrap modulo 2^ADDR_W.
//   - Exactly one mode line is high, selected by the latched mode.
//   - Exit when pass==k-1 && slot==SLOTS-1.
//  DRAIN
//   - res_valid=1 and mode lines=0, so the array keeps its contents.
//   - On res_ready: res_valid falls, done pulses for 1 cycle, state returns to IDLE.
//   - res_ready outside DRAIN is ignored.
//  Latency: accept at cycle T -> CLEAR at T+1 -> RUN over T+2..T+1+16k -> res_valid from T+2+16k.
//  Mode lines are zero in every state except RUN, never more than one-hot, and never change mid-job.
//  cmd_valid while busy: held off by cmd_ready=0. No command queueing.
//  rst_n asserted mid-job: the job is abandoned and mac_rst_n is forced to 1.
//   The array clears through its own rst_n.
// CONFIGURATION
//  MAC_SEQ_PERF_EN defined
//   - Adds output perf_busy_cyc[31:0]: counts cycles not in IDLE, saturating.
//   - Adds output perf_jobs[15:0]: counts done pulses, wrapping.
//   - Both counters reset to 0.
//  MAC_SEQ_PERF_EN undefined: neither port nor either counter exists. Functional behaviour is identical.
// STRUCTURE
//  Shared package mac_pkg holds:
//   - mode encodings MODE_INT8/INT4/VSQ/ILLEGAL
//   - MAC_SLOTS=16, MAC_LANES=16, PSUM_W=24
//   - FSM state encoding
//  Sub-module mac_seq_addr_gen: slot/pass counters plus address adders.
//   Inputs: start, k, bases. Outputs: a_addr, b_addr, last.
//  The FSM and handshakes stay in the top level.
// TESTING
//  1. INT8 job, k=2, a_base=0x010, b_base=0x020 -> mac_rst_n low 1 cycle; 32 RUN cycles;
//     a_addr runs 0x010..0x02F; b_addr is 0x020 x16 then 0x021 x16; res_valid at T+34.
//  2. Mode 3 -> no mac_rst_n pulse and no buf_rd_en; err=1, done pulses at T+1; a following
//     valid INT4 command clears err.
//  3. k=0, VSQ -> CLEAR then DRAIN directly; zero RUN cycles; mode lines stay 0.
//  4. a_base=0x3F8, k=1, ADDR_W=10 -> a_addr wraps 0x3FF->0x000 at slot 8.
//  5. Hold res_ready=0 for 50 cycles in DRAIN with cmd_valid=1 -> res_valid held, cmd_ready=0;
//     release -> done pulse, then the command is accepted the next cycle.
//  6. Drop rst_n at RUN slot 7 -> all outputs return to reset values asynchronously;
//     a new job after release runs normally.

Source files
------------

// File: rtl/mac_pkg.sv
// mac_pkg: encodings shared by the MAC array and its job sequencer.
package mac_pkg;

  localparam int MAC_SLOTS = 16;
  localparam int MAC_LANES = 16;
  localparam int PSUM_W    = 24;

  typedef enum logic [1:0] {
    MODE_INT8    = 2'd0,
    MODE_INT4    = 2'd1,
    MODE_VSQ     = 2'd2,
    MODE_ILLEGAL = 2'd3
  } mac_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } mac_state_e;

  // One-hot {int8, int4, vsq} line pattern for a mode; illegal drives nothing.
  function automatic logic [2:0] mode_lines(mac_mode_e m);
    logic [2:0] l;
    l = 3'b000;
    case (m)
      MODE_INT8: l = 3'b100;
      MODE_INT4: l = 3'b010;
      MODE_VSQ:  l = 3'b001;
      default:   l = 3'b000;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/mac_seq_addr_gen.sv
// mac_seq_addr_gen: slot/pass counters and A/B operand-buffer address adders.
// start zeroes both counters; step advances slot, carrying into pass on wrap.
module mac_seq_addr_gen
  import mac_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int K_W    = 8,
  parameter int SLOTS  = MAC_SLOTS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              step,
  input  logic [K_W-1:0]    k,
  input  logic [ADDR_W-1:0] a_base,
  input  logic [ADDR_W-1:0] b_base,
  output logic [ADDR_W-1:0] a_addr,
  output logic [ADDR_W-1:0] b_addr,
  output logic              last
);

  localparam int SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int OFF_W  = K_W + SLOT_W;

  logic [SLOT_W-1:0] slot_q;
  logic [K_W-1:0]    pass_q;
  logic [OFF_W-1:0]  offset;
  logic              slot_wrap;

  assign slot_wrap = (slot_q == SLOT_W'(SLOTS - 1));

  // Slot counter wraps every SLOTS steps and bumps the pass counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q <= '0;
      pass_q <= '0;
    end else if (start) begin
      slot_q <= '0;
      pass_q <= '0;
    end else if (step) begin
      if (slot_wrap) begin
        slot_q <= '0;
        pass_q <= pass_q + K_W'(1);
      end else begin
        slot_q <= slot_q + SLOT_W'(1);
      end
    end
  end

  // Addresses truncate to ADDR_W, so both wrap modulo 2^ADDR_W.
  always_comb begin
    offset = OFF_W'(pass_q) * OFF_W'(SLOTS) + OFF_W'(slot_q);
    a_addr = a_base + ADDR_W'(offset);
    b_addr = b_base + ADDR_W'(pass_q);
    last   = (pass_q == (k - K_W'(1))) && slot_wrap;
  end

endmodule

// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: GEMM tile job sequencer for the 16-lane MAC array.
// Flow: IDLE -> CLEAR (1 cycle) -> RUN (16*k cycles) -> DRAIN -> IDLE.
// Optional build macro MAC_SEQ_PERF_EN adds perf_busy_cyc / perf_jobs counters.
// Handshakes: a command transfers on a cycle where cmd_valid && cmd_ready; a
// result is held (res_valid=1) until a cycle where res_valid && res_ready.
module mac_seq_ctrl
  import mac_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int K_W    = 8,
  parameter int SLOTS  = MAC_SLOTS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_mode,
  input  logic [K_W-1:0]    cmd_k,
  input  logic [ADDR_W-1:0] cmd_a_base,
  input  logic [ADDR_W-1:0] cmd_b_base,
  output logic              buf_rd_en,
  output logic [ADDR_W-1:0] a_addr,
  output logic [ADDR_W-1:0] b_addr,
  output logic              mac_rst_n,
  output logic              is_int8_mode,
  output logic              is_int4_mode,
  output logic              is_vsq,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              done,
  output logic              err,
`ifdef MAC_SEQ_PERF_EN
  output logic [31:0]       perf_busy_cyc,
  output logic [15:0]       perf_jobs,
`endif
  output mac_state_e        dbg_state
);

  mac_state_e        state_q, state_d;
  mac_mode_e         mode_q;
  logic [K_W-1:0]    k_q;
  logic [ADDR_W-1:0] a_base_q, b_base_q;
  logic [ADDR_W-1:0] gen_a_addr, gen_b_addr;
  logic              gen_start, gen_step, gen_last;
  logic              cmd_fire, cmd_illegal;

  // cmd_ready is exactly "state is IDLE", so fire is derived from state directly.
  assign cmd_fire    = cmd_valid && (state_q == ST_IDLE);
  assign cmd_illegal = (mac_mode_e'(cmd_mode) == MODE_ILLEGAL);
  assign dbg_state   = state_q;

  // State register; reset abandons any job and returns to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Capture job parameters on a legal accepted command; they stay fixed for the job.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q   <= MODE_INT8;
      k_q      <= '0;
      a_base_q <= '0;
      b_base_q <= '0;
    end else if (cmd_fire && !cmd_illegal) begin
      mode_q   <= mac_mode_e'(cmd_mode);
      k_q      <= cmd_k;
      a_base_q <= cmd_a_base;
      b_base_q <= cmd_b_base;
    end
  end

  // done pulses after an illegal accept or a consumed result; err is sticky per command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done <= 1'b0;
      err  <= 1'b0;
    end else begin
      done <= (cmd_fire && cmd_illegal) || ((state_q == ST_DRAIN) && res_ready);
      if (cmd_fire) err <= cmd_illegal;
    end
  end

  // Next-state and per-state outputs; mode lines only ever driven in RUN.
  always_comb begin
    state_d      = state_q;
    cmd_ready    = 1'b0;
    mac_rst_n    = 1'b1;
    buf_rd_en    = 1'b0;
    res_valid    = 1'b0;
    is_int8_mode = 1'b0;
    is_int4_mode = 1'b0;
    is_vsq       = 1'b0;
    gen_start    = 1'b0;
    gen_step     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid && !cmd_illegal) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        // Clearing the array here also zeroes its slot counter, lining it up with ours.
        mac_rst_n = 1'b0;
        gen_start = 1'b1;
        state_d   = (k_q == '0) ? ST_DRAIN : ST_RUN;
      end
      ST_RUN: begin
        buf_rd_en = 1'b1;
        gen_step  = 1'b1;
        {is_int8_mode, is_int4_mode, is_vsq} = mode_lines(mode_q);
        if (gen_last) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        res_valid = 1'b1;
        if (res_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  mac_seq_addr_gen #(
    .ADDR_W (ADDR_W),
    .K_W    (K_W),
    .SLOTS  (SLOTS)
  ) u_addr_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (gen_start),
    .step   (gen_step),
    .k      (k_q),
    .a_base (a_base_q),
    .b_base (b_base_q),
    .a_addr (gen_a_addr),
    .b_addr (gen_b_addr),
    .last   (gen_last)
  );

  // Addresses are only meaningful while reading; hold them at zero otherwise.
  assign a_addr = buf_rd_en ? gen_a_addr : '0;
  assign b_addr = buf_rd_en ? gen_b_addr : '0;

`ifdef MAC_SEQ_PERF_EN
  // Busy cycles saturate at all-ones; completed jobs wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_busy_cyc <= '0;
      perf_jobs     <= '0;
    end else begin
      if ((state_q != ST_IDLE) && (perf_busy_cyc != 32'hFFFF_FFFF))
        perf_busy_cyc <= perf_busy_cyc + 32'd1;
      if (done)
        perf_jobs <= perf_jobs + 16'd1;
    end
  end
`else
  // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// tb_mac_seq_ctrl: self-checking bench for mac_seq_ctrl (default build).
module tb_mac_seq_ctrl;
  import mac_pkg::*;

  localparam int ADDR_W = 10;
  localparam int K_W    = 8;
  localparam int SLOTS  = 16;

  // Expected control vectors {cmd_ready, mac_rst_n, buf_rd_en, int8, int4, vsq, res_valid, done}
  localparam logic [7:0] CTL_IDLE  = 8'b1100_0000;
  localparam logic [7:0] CTL_CLEAR = 8'b0000_0000;
  localparam logic [7:0] CTL_DRAIN = 8'b0100_0010;
  localparam logic [7:0] CTL_DONE  = 8'b1100_0001;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [1:0]        cmd_mode = 2'd0;
  logic [K_W-1:0]    cmd_k = '0;
  logic [ADDR_W-1:0] cmd_a_base = '0;
  logic [ADDR_W-1:0] cmd_b_base = '0;
  logic              buf_rd_en;
  logic [ADDR_W-1:0] a_addr, b_addr;
  logic              mac_rst_n, is_int8_mode, is_int4_mode, is_vsq;
  logic              res_valid;
  logic              res_ready = 1'b0;
  logic              done, err;
  mac_state_e        dbg_state;
`ifdef MAC_SEQ_PERF_EN
  logic [31:0]       perf_busy_cyc;
  logic [15:0]       perf_jobs;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [ADDR_W-1:0] exp_a_q[$];
  logic [ADDR_W-1:0] exp_b_q[$];

  mac_seq_ctrl #(.ADDR_W(ADDR_W), .K_W(K_W), .SLOTS(SLOTS)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_mode     (cmd_mode),
    .cmd_k        (cmd_k),
    .cmd_a_base   (cmd_a_base),
    .cmd_b_base   (cmd_b_base),
    .buf_rd_en    (buf_rd_en),
    .a_addr       (a_addr),
    .b_addr       (b_addr),
    .mac_rst_n    (mac_rst_n),
    .is_int8_mode (is_int8_mode),
    .is_int4_mode (is_int4_mode),
    .is_vsq       (is_vsq),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .done         (done),
    .err          (err),
`ifdef MAC_SEQ_PERF_EN
    .perf_busy_cyc(perf_busy_cyc),
    .perf_jobs    (perf_jobs),
`endif
    .dbg_state    (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Watchdog: the bench must never hang.
  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  // Mode line table: mode 0 -> int8, 1 -> int4, 2 -> vsq.
  function automatic logic [2:0] lines_for(int mode);
    case (mode)
      0:       return 3'b100;
      1:       return 3'b010;
      2:       return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [7:0] snap_ctl();
    return {cmd_ready, mac_rst_n, buf_rd_en, is_int8_mode, is_int4_mode, is_vsq, res_valid, done};
  endfunction

  // Driver: present a command for one rising edge (caller sits at a negedge in IDLE).
  task automatic send_cmd(input int mode, input int k, input int a_base, input int b_base);
    cmd_mode   = 2'(mode);
    cmd_k      = K_W'(k);
    cmd_a_base = ADDR_W'(a_base);
    cmd_b_base = ADDR_W'(b_base);
    cmd_valid  = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [8+2*ADDR_W:0] got;
    rst_n = 1'b0;
    #3;
    got = {snap_ctl(), err, a_addr, b_addr};
    n_checks++;
    if (got !== {CTL_IDLE, 1'b0, {2*ADDR_W{1'b0}}}) begin
      n_fail++;
      $display("FAIL reset_outputs got=%h exp=%h", got, {CTL_IDLE, 1'b0, {2*ADDR_W{1'b0}}});
    end
    n_checks++;
    if (dbg_state !== ST_IDLE) begin
      n_fail++;
      $display("FAIL reset_state got=%0d exp=%0d", dbg_state, ST_IDLE);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Full legal job: every cycle from accept to the end of the done pulse is checked
  // against the timeline T+1 CLEAR, 16k RUN cycles, then DRAIN until res_ready.
  task automatic test_job(input string name, input int mode, input int k,
                          input int a_base, input int b_base, input bit noise);
    logic [7:0] ctl;
    logic [ADDR_W-1:0] ea, eb;
    int idx;
    int hold;
    exp_a_q.delete();
    exp_b_q.delete();
    for (int p = 0; p < k; p++) begin
      for (int s = 0; s < SLOTS; s++) begin
        exp_a_q.push_back(ADDR_W'((a_base + p * SLOTS + s) % (1 << ADDR_W)));
        exp_b_q.push_back(ADDR_W'((b_base + p) % (1 << ADDR_W)));
      end
    end
    @(negedge clk);
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s idle_ready got=%b exp=1", name, cmd_ready);
    end
    send_cmd(mode, k, a_base, b_base);
    @(negedge clk);
    ctl = snap_ctl();
    n_checks++;
    if (ctl !== CTL_CLEAR) begin
      n_fail++;
      $display("FAIL %s clear_ctl got=%b exp=%b", name, ctl, CTL_CLEAR);
    end
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL %s err_after_accept got=%b exp=0", name, err);
    end
    res_ready = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    idx = 0;
    while (exp_a_q.size() > 0) begin
      @(negedge clk);
      ea  = exp_a_q.pop_front();
      eb  = exp_b_q.pop_front();
      ctl = snap_ctl();
      n_checks++;
      if (ctl !== {3'b011, lines_for(mode), 2'b00}) begin
        n_fail++;
        $display("FAIL %s run_ctl[%0d] got=%b exp=%b", name, idx, ctl, {3'b011, lines_for(mode), 2'b00});
      end
      n_checks++;
      if ({a_addr, b_addr} !== {ea, eb}) begin
        n_fail++;
        $display("FAIL %s run_addr[%0d] got a=%h b=%h exp a=%h b=%h", name, idx, a_addr, b_addr, ea, eb);
      end
      res_ready = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      idx++;
    end
    @(negedge clk);
    res_ready = 1'b0;
    ctl = snap_ctl();
    n_checks++;
    if (ctl !== CTL_DRAIN) begin
      n_fail++;
      $display("FAIL %s drain_ctl got=%b exp=%b", name, ctl, CTL_DRAIN);
    end
    hold = $urandom_range(0, 3);
    repeat (hold) begin
      @(negedge clk);
      ctl = snap_ctl();
      n_checks++;
      if (ctl !== CTL_DRAIN) begin
        n_fail++;
        $display("FAIL %s drain_hold_ctl got=%b exp=%b", name, ctl, CTL_DRAIN);
      end
    end
    res_ready = 1'b1;
    @(posedge clk);
    #1 res_ready = 1'b0;
    @(negedge clk);
    ctl = snap_ctl();
    n_checks++;
    if (ctl !== CTL_DONE) begin
      n_fail++;
      $display("FAIL %s done_ctl got=%b exp=%b", name, ctl, CTL_DONE);
    end
    @(negedge clk);
    ctl = snap_ctl();
    n_checks++;
    if (ctl !== CTL_IDLE) begin
      n_fail++;
      $display("FAIL %s idle_after_ctl got=%b exp=%b", name, ctl, CTL_IDLE);
    end
  endtask

  task automatic test_int8_k2();
    test_job("int8_k2", 0, 2, 'h010, 'h020, 1'b0);
  endtask

  task automatic test_illegal();
    logic [7:0] ctl;
    @(negedge clk);
    send_cmd(3, 2, 'h055, 'h066);
    @(negedge clk);
    ctl = snap_ctl();
    n_checks++;
    if ({ctl, err} !== {CTL_DONE, 1'b1}) begin
      n_fail++;
      $display("FAIL illegal_first got ctl=%b err=%b exp ctl=%b err=1", ctl, err, CTL_DONE);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ctl = snap_ctl();
      n_checks++;
      if ({ctl, err} !== {CTL_IDLE, 1'b1}) begin
        n_fail++;
        $display("FAIL illegal_idle[%0d] got ctl=%b err=%b exp ctl=%b err=1", i, ctl, err, CTL_IDLE);
      end
    end
    // A legal INT4 command must clear err; test_job checks err=0 after accept.
    test_job("int4_after_illegal", 1, 1, 'h100, 'h200, 1'b0);
  endtask

  task automatic test_k0_vsq();
    test_job("vsq_k0", 2, 0, 'h123, 'h321, 1'b0);
  endtask

  task automatic test_addr_wrap();
    test_job("a_wrap", 1, 1, 'h3F8, 'h3FF, 1'b0);
  endtask

  task automatic test_drain_hold();
    logic [7:0] ctl;
    int waited;
    @(negedge clk);
    send_cmd(0, 1, 'h040, 'h080);
    waited = 0;
    while (res_valid !== 1'b1 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    n_checks++;
    if (res_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL drain_hold_wait res_valid got=%b exp=1 after %0d cycles", res_valid, waited);
    end
    cmd_mode   = 2'd1;
    cmd_k      = '0;
    cmd_a_base = ADDR_W'('h011);
    cmd_b_base = ADDR_W'('h022);
    cmd_valid  = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      ctl = snap_ctl();
      n_checks++;
      if (ctl !== CTL_DRAIN) begin
        n_fail++;
        $display("FAIL drain_hold[%0d] got=%b exp=%b", i, ctl, CTL_DRAIN);
      end
    end
    res_ready = 1'b1;
    @(posedge clk);
    #1 res_ready = 1'b0;
    @(negedge clk);
    ctl = snap_ctl();
    n_checks++;
    if (ctl !== CTL_DONE) begin
      n_fail++;
      $display("FAIL drain_release got=%b exp=%b", ctl, CTL_DONE);
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    ctl = snap_ctl();
    n_checks++;
    if (ctl !== CTL_CLEAR) begin
      n_fail++;
      $display("FAIL held_cmd_accept got=%b exp=%b", ctl, CTL_CLEAR);
    end
    @(negedge clk);
    ctl = snap_ctl();
    n_checks++;
    if (ctl !== CTL_DRAIN) begin
      n_fail++;
      $display("FAIL held_cmd_drain got=%b exp=%b", ctl, CTL_DRAIN);
    end
    res_ready = 1'b1;
    @(posedge clk);
    #1 res_ready = 1'b0;
    @(negedge clk);
    ctl = snap_ctl();
    n_checks++;
    if (ctl !== CTL_DONE) begin
      n_fail++;
      $display("FAIL held_cmd_done got=%b exp=%b", ctl, CTL_DONE);
    end
  endtask

  task automatic test_reset_mid();
    logic [8+2*ADDR_W:0] got;
    @(negedge clk);
    send_cmd(1, 2, 'h200, 'h300);
    @(negedge clk);
    repeat (8) @(negedge clk);
    n_checks++;
    if ({buf_rd_en, a_addr} !== {1'b1, ADDR_W'('h207)}) begin
      n_fail++;
      $display("FAIL reset_mid_slot7 got en=%b a=%h exp en=1 a=207", buf_rd_en, a_addr);
    end
    rst_n = 1'b0;
    #1;
    got = {snap_ctl(), err, a_addr, b_addr};
    n_checks++;
    if (got !== {CTL_IDLE, 1'b0, {2*ADDR_W{1'b0}}}) begin
      n_fail++;
      $display("FAIL reset_mid_outputs got=%h exp=%h", got, {CTL_IDLE, 1'b0, {2*ADDR_W{1'b0}}});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    test_job("after_reset", 2, 1, 'h00F, 'h0F0, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      test_job($sformatf("rand%0d", i), $urandom_range(0, 2), $urandom_range(0, 3),
               $urandom_range(0, 1023), $urandom_range(0, 1023), 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_int8_k2();
    test_illegal();
    test_k0_vsq();
    test_addr_wrap();
    test_drain_hold();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
